fp_mul_seq: RTL

Parametrised, sequential IEEE-754-style floating-point multiplier. It generalises the team's combinational half-precision multiplier in three ways:
- configurable exponent and mantissa widths;
- an iterative radix-4 Booth significand datapath that retires 2 multiplier bits per cycle;
- round-to-nearest-even, with valid/ready handshakes on input and output.

It sits between the operand register file and the FP writeback arbiter in the fp_alu.

---
 rtl/fp_mul_seq.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: iterative IEEE-754-style floating-point multiplier.
// The significand product is built by a radix-4 Booth datapath that retires two
// multiplier bits per cycle. The result is rounded to nearest-even and returned
// through a valid/ready handshake. Subnormal operands are flushed to zero.
module fp_mul_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BIAS  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_p,
    output logic [1:0]           out_exc
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int S    = MAN_W + 1;
    localparam int ITER = (MAN_W + 3) / 2;
    localparam int AW   = 2 * S + 2;
    localparam int QW   = 2 * ITER + 1;
    localparam int EW   = EXP_W + 2;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [CW-1:0]        ITER_C = CW'(ITER);
    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EZERO  = '0;
    localparam logic [W-1:0]         QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, NORM, HOLD} state_t;

    // Control and reset-cleared state
    state_t                  state_q, state_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [W-1:0]            out_p_q, out_p_d;
    logic [1:0]              out_exc_q, out_exc_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    // Operand-derived datapath state, captured on accept
    logic [S-1:0]            mcand_q, mcand_d;
    logic [QW-1:0]           mplr_q, mplr_d;
    logic signed [EW-1:0]    exp_q, exp_d;
    logic                    sign_q, sign_d;
    logic                    nan_q, nan_d;
    logic                    inf_q, inf_d;
    logic                    zero_q, zero_d;

    // Operand fields and classes
    logic                    a_s, b_s;
    logic [EXP_W-1:0]        a_e, b_e;
    logic [MAN_W-1:0]        a_m, b_m;
    logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign {a_s, a_e, a_m} = in_a;
    assign {b_s, b_e, b_m} = in_b;
    assign a_zero = (a_e == '0);
    assign b_zero = (b_e == '0);
    assign a_inf  = (&a_e) & ~(|a_m);
    assign b_inf  = (&b_e) & ~(|b_m);
    assign a_nan  = (&a_e) & (|a_m);
    assign b_nan  = (&b_e) & (|b_m);

    // Normalise the 2S-bit product and round it to nearest-even.
    // Returns {norm_inc, round_carry, fraction}. Any accumulator bit at or
    // above 2S-1 means the product lies in [2,4) and needs a right shift.
    function automatic logic [MAN_W+1:0] round_rne(input logic signed [AW-1:0] acc);
        logic           hi;
        logic [2*S-1:0] n;
        logic           g, r, st, up;
        logic [S:0]     sig;
        logic [MAN_W-1:0] frac;
        hi   = |acc[AW-1:2*S-1];
        n    = hi ? acc[2*S-1:0] : {acc[2*S-2:0], 1'b0};
        g    = n[S-1];
        r    = n[S-2];
        st   = |n[S-3:0];
        up   = g & (r | st | n[S]);
        sig  = {1'b0, n[2*S-1:S]} + {{S{1'b0}}, up};
        // A carry out of the rounded significand renormalises by one more place.
        frac = sig[S] ? sig[MAN_W:1] : sig[MAN_W-1:0];
        return {hi, sig[S], frac};
    endfunction

    // Resolve operand classes and exponent range into {exc, product}, highest
    // priority first: NaN / Inf*0, Inf, zero operand, overflow, underflow.
    function automatic logic [W+1:0] pack_result(input logic s, input logic nan,
                                                 input logic inf, input logic zero,
                                                 input logic signed [EW-1:0] e,
                                                 input logic [MAN_W-1:0] frac);
        logic [W-1:0] p;
        logic [1:0]   exc;
        if (nan) begin
            p   = QNAN;
            exc = 2'b11;
        end else if (inf) begin
            p   = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            exc = 2'b11;
        end else if (zero) begin
            p   = {s, {(W-1){1'b0}}};
            exc = 2'b00;
        end else if (e >= EMAX_E) begin
            p   = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            exc = 2'b01;
        end else if (e <= EZERO) begin
            p   = {s, {(W-1){1'b0}}};
            exc = 2'b10;
        end else begin
            p   = {s, e[EXP_W-1:0], frac};
            exc = 2'b00;
        end
        return {exc, p};
    endfunction

    logic signed [AW-1:0] mc_ext;
    logic signed [AW-1:0] booth_term;
    logic [CW:0]          shamt;
    logic [MAN_W+1:0]     rnd;
    logic signed [EW-1:0] e_fin;
    logic [W+1:0]         res;

    assign mc_ext = $signed({{(AW-S){1'b0}}, mcand_q});
    assign shamt  = {cnt_q, 1'b0};
    assign rnd    = round_rne(acc_q);
    assign e_fin  = exp_q + EW'(rnd[MAN_W+1]) + EW'(rnd[MAN_W]);
    assign res    = pack_result(sign_q, nan_q, inf_q, zero_q, e_fin, rnd[MAN_W-1:0]);

    // Booth recoding of the current multiplier triplet into 0, +-M or +-2M
    always_comb begin
        booth_term = '0;
        case (mplr_q[2:0])
            3'b001, 3'b010: booth_term = mc_ext;
            3'b011:         booth_term = mc_ext <<< 1;
            3'b100:         booth_term = -(mc_ext <<< 1);
            3'b101, 3'b110: booth_term = -mc_ext;
            default:        booth_term = '0;
        endcase
    end

    // Next state: accept operands, iterate Booth steps, normalise/round, hold result
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
        out_exc_d   = out_exc_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplr_d      = mplr_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        nan_d       = nan_q;
        inf_d       = inf_q;
        zero_d      = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d     = a_s ^ b_s;
                    exp_d      = $signed({2'b00, a_e}) + $signed({2'b00, b_e}) - BIAS_E;
                    mcand_d    = {1'b1, a_m};
                    // Multiplier zero-extended for unsigned Booth, with the implicit 0 below the LSB
                    mplr_d     = {{(QW-S-1){1'b0}}, 1'b1, b_m, 1'b0};
                    nan_d      = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
                    inf_d      = a_inf | b_inf;
                    zero_d     = a_zero | b_zero;
                    acc_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = MUL;
                end
            end
            MUL: begin
                if (cnt_q == ITER_C) begin
                    state_d = NORM;
                end else begin
                    acc_d  = acc_q + (booth_term <<< shamt);
                    mplr_d = mplr_q >> 2;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            NORM: begin
                out_exc_d   = res[W+1:W];
                out_p_d     = res[W-1:0];
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, handshake outputs, accumulator and step counter; reset aborts any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_exc_q   <= 2'b00;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
            out_exc_q   <= out_exc_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    // Operand datapath registers, only meaningful after an accept
    always_ff @(posedge clk) begin
        mcand_q <= mcand_d;
        mplr_q  <= mplr_d;
        exp_q   <= exp_d;
        sign_q  <= sign_d;
        nan_q   <= nan_d;
        inf_q   <= inf_d;
        zero_q  <= zero_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_exc   = out_exc_q;

endmodule
